rv_fetch_ctrl: RTL and testbench
================================

Name: rv_fetch_ctrl

Overview:
- Instruction-fetch front end directly upstream of the fetch buffer (the 8-entry, 16-bit-halfword queue).
- Issues 32-bit-aligned word requests on the instruction bus and splits each returned word into lo/hi halfwords.
- Drives the buffer's push_single/push_double and clear/PC-load inputs.
- Handles misaligned (pc[1]=1) start addresses, back-pressure from buffer fullness, and redirect (flush) requests that arrive while a bus request is outstanding.

Parameters:
- IADDR_SPACE_BITS, 16, instruction address width in bytes; PC carried as [IADDR_SPACE_BITS-1:1].
- RESET_PC, 0, halfword-granular PC loaded at reset.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_flush  in  1  one-cycle redirect pulse from execute.
- i_flush_pc  in  IADDR_SPACE_BITS-1  redirect target, [IADDR_SPACE_BITS-1:1].
- o_ibus_req  out  1  bus request.
- o_ibus_addr  out  IADDR_SPACE_BITS-2  word address, [IADDR_SPACE_BITS-1:2].
- i_ibus_ack  in  1  bus response valid; data accompanies ack.
- i_ibus_data  in  32  fetched word.
- i_buf_not_full  in  1  from buffer; at least 4 halfwords free.
- o_buf_clear_n  out  1  drives buffer reset_n (clears head, loads PC).
- o_buf_pc  out  IADDR_SPACE_BITS-1  PC loaded into buffer while clear_n=0.
- o_data_lo  out  16  i_ibus_data[15:0], registered.
- o_data_hi  out  16  i_ibus_data[31:16], registered.
- o_push_single  out  1  push hi halfword only.
- o_push_double  out  1  push lo then hi.

Behaviour:
- Reset (async) values:
  - req=0, push_single=0, push_double=0, clear_n=0.
  - o_buf_pc=RESET_PC, fetch address fa=RESET_PC, skip_lo=RESET_PC[1].
  - data_lo=data_hi=0, state=ST_CLEAR.
- State machine:
  - ST_CLEAR: lasts one cycle; clear_n=0; then goes to ST_IDLE with clear_n=1.
  - ST_IDLE: if i_buf_not_full, assert req with addr=fa[..2] and go to ST_REQ; else stay in ST_IDLE.
  - ST_REQ: req and addr held stable until ack.
    - On ack: capture data; next-cycle push_double=!skip_lo, push_single=skip_lo.
    - Then fa=(fa[..2]+1)<<1 (lo bit of halfword address cleared) and skip_lo=0.
    - If i_buf_not_full in the ack cycle, req stays high with the new address (back-to-back); else go to ST_IDLE.
  - ST_DROP: an old request is still outstanding after a flush. Keep req/addr until ack, discard the data (no push), then go to ST_IDLE.
- Fetch-address arithmetic:
  - fa increment is word-granular.
  - Wrap at 2^IADDR_SPACE_BITS is modulo, no error.
- Push latency: exactly 1 cycle after ack; data_lo/hi are valid in the same cycle as the push.
- Invariant: at most one registered push is in flight when a new request is issued.
  - An issue gated by not_full (head ≤4) plus a pending push (≤2) plus the new push (≤2) gives ≤8, which never overflows the 8-entry buffer.
- Flush (i_flush=1 in cycle T):
  - T+1:
    - clear_n=0, o_buf_pc=i_flush_pc, fa=i_flush_pc, skip_lo=i_flush_pc[1].
    - Any push scheduled for T+1 is forced to 0.
  - If a request is outstanding without ack in T, go to ST_DROP. Otherwise go to ST_CLEAR-equivalent, then ST_IDLE.
  - An ack coinciding with the flush in T: its data is discarded.
  - A flush during ST_DROP or ST_CLEAR: the newest target wins; clear is re-asserted for one more cycle.
- Reset mid-request: all state returns to reset values immediately. The bus is required to tolerate req dropping without ack.
- i_buf_not_full is only sampled when deciding to issue; an accepted request always completes.

Decomposition:
- Shared core package:
  - fetch state enum (ST_CLEAR, ST_IDLE, ST_REQ, ST_DROP).
  - Halfword/word width constants (16/32).
- Word-address incrementer: reuse the existing generic add module (WIDTH=IADDR_SPACE_BITS-2, carry-in 1'b0). No new sub-module.

Test Plan:
- Reset with RESET_PC=0: clear_n low for 1 cycle after release, then req=1, addr=0. Ack with data 0x00130013 -> next cycle push_double=1, lo=0x0013, hi=0x0013, next addr=1.
- Misaligned start: flush_pc=0x0003 (byte 0x6) -> buf_pc=0x0003, addr=1. Ack with data 0xAAAA5555 -> push_single=1, hi=0xAAAA, lo is don't-care; next addr=2 with push_double.
- Back-pressure: hold i_buf_not_full=0 after an ack -> req deasserts, no further pushes. Raise not_full -> req re-asserts on the following cycle with the incremented address.
- Flush during outstanding request: req pending at addr 5, flush_pc=0x0040 -> clear_n=0 one cycle. Delayed ack at addr 5 -> no push. Next request at addr 0x20.
- Flush coincident with ack: ack at addr 3 and flush_pc=0x0010 in the same cycle -> no push next cycle, clear_n=0; next request at addr 8.
- Back-to-back throughput with ack every cycle and not_full=1: one push_double per cycle, addresses 0,1,2,3 consecutive; address wrap at max is modulo (max -> 0).

Source files
------------

// File: rtl/rv_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM states and
// halfword/word widths.
package rv_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_REQ   = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_t;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

endpackage

// File: rtl/rv_fetch_ctrl_add.sv
// Generic combinational adder with carry-in; the sum wraps modulo 2^WIDTH.
module rv_fetch_ctrl_add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b + {{(WIDTH-1){1'b0}}, cin};

endmodule

// File: rtl/rv_fetch_ctrl.sv
// Fetch controller: issues word requests, splits returned words into halfwords
// and pushes them into the fetch buffer, handling misaligned starts and flushes.
module rv_fetch_ctrl
  import rv_fetch_ctrl_pkg::*;
#(
  parameter int                         IADDR_SPACE_BITS = 16,
  parameter logic [IADDR_SPACE_BITS-1:1] RESET_PC        = '0
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_flush,
  input  logic [IADDR_SPACE_BITS-1:1]   i_flush_pc,
  output logic                          o_ibus_req,
  output logic [IADDR_SPACE_BITS-1:2]   o_ibus_addr,
  input  logic                          i_ibus_ack,
  input  logic [WORD_W-1:0]             i_ibus_data,
  input  logic                          i_buf_not_full,
  output logic                          o_buf_clear_n,
  output logic [IADDR_SPACE_BITS-1:1]   o_buf_pc,
  output logic [HALF_W-1:0]             o_data_lo,
  output logic [HALF_W-1:0]             o_data_hi,
  output logic                          o_push_single,
  output logic                          o_push_double
);

  localparam int WA_W = IADDR_SPACE_BITS - 2;

  fetch_state_t                 state;
  logic [IADDR_SPACE_BITS-1:1]  fa;
  logic                         skip_lo;
  logic [WA_W-1:0]              fa_word_inc;

  rv_fetch_ctrl_add #(
    .WIDTH (WA_W)
  ) u_fa_inc (
    .a   (fa[IADDR_SPACE_BITS-1:2]),
    .b   ({{(WA_W-1){1'b0}}, 1'b1}),
    .cin (1'b0),
    .sum (fa_word_inc)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= ST_CLEAR;
      fa            <= RESET_PC;
      skip_lo       <= RESET_PC[1];
      o_ibus_req    <= 1'b0;
      o_ibus_addr   <= '0;
      o_buf_clear_n <= 1'b0;
      o_buf_pc      <= RESET_PC;
      o_data_lo     <= '0;
      o_data_hi     <= '0;
      o_push_single <= 1'b0;
      o_push_double <= 1'b0;
    end else begin
      // Pushes and clear are single-cycle pulses unless re-armed below.
      o_push_single <= 1'b0;
      o_push_double <= 1'b0;
      o_buf_clear_n <= 1'b1;

      if (i_flush) begin
        o_buf_clear_n <= 1'b0;
        o_buf_pc      <= i_flush_pc;
        fa            <= i_flush_pc;
        skip_lo       <= i_flush_pc[1];
        // An unacked request must still be seen through; its data is dropped.
        if (o_ibus_req && !i_ibus_ack) begin
          state <= ST_DROP;
        end else begin
          state      <= ST_CLEAR;
          o_ibus_req <= 1'b0;
        end
      end else begin
        case (state)
          ST_CLEAR: begin
            state <= ST_IDLE;
          end
          ST_IDLE: begin
            if (i_buf_not_full) begin
              o_ibus_req  <= 1'b1;
              o_ibus_addr <= fa[IADDR_SPACE_BITS-1:2];
              state       <= ST_REQ;
            end
          end
          ST_REQ: begin
            if (i_ibus_ack) begin
              o_data_lo     <= i_ibus_data[HALF_W-1:0];
              o_data_hi     <= i_ibus_data[WORD_W-1:HALF_W];
              o_push_double <= !skip_lo;
              o_push_single <= skip_lo;
              fa            <= {fa_word_inc, 1'b0};
              skip_lo       <= 1'b0;
              if (i_buf_not_full) begin
                o_ibus_addr <= fa_word_inc;
              end else begin
                o_ibus_req <= 1'b0;
                state      <= ST_IDLE;
              end
            end
          end
          ST_DROP: begin
            if (i_ibus_ack) begin
              o_ibus_req <= 1'b0;
              state      <= ST_IDLE;
            end
          end
          default: state <= ST_CLEAR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// Directed bench for rv_fetch_ctrl: reset, aligned/misaligned fetch,
// back-pressure, flush variants, back-to-back throughput and address wrap.
module tb_rv_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [15:1] flush_pc;
  logic        ibus_req;
  logic [15:2] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_data;
  logic        buf_not_full;
  logic        buf_clear_n;
  logic [15:1] buf_pc;
  logic [15:0] data_lo;
  logic [15:0] data_hi;
  logic        push_single;
  logic        push_double;

  int compared   = 0;
  int mismatched = 0;

  rv_fetch_ctrl #(
    .IADDR_SPACE_BITS (16),
    .RESET_PC         (15'h0000)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_flush        (flush),
    .i_flush_pc     (flush_pc),
    .o_ibus_req     (ibus_req),
    .o_ibus_addr    (ibus_addr),
    .i_ibus_ack     (ibus_ack),
    .i_ibus_data    (ibus_data),
    .i_buf_not_full (buf_not_full),
    .o_buf_clear_n  (buf_clear_n),
    .o_buf_pc       (buf_pc),
    .o_data_lo      (data_lo),
    .o_data_hi      (data_hi),
    .o_push_single  (push_single),
    .o_push_double  (push_double)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compact check of the bus/push/clear outputs after an edge.
  task automatic chk_ctl(input string tag, input logic req, input logic [13:0] addr,
                         input logic ps, input logic pd, input logic cn);
    $display("step %s: req=%0b addr=%h ps=%0b pd=%0b clear_n=%0b",
             tag, ibus_req, ibus_addr, push_single, push_double, buf_clear_n);
    chk({tag, ".req"}, {31'd0, ibus_req}, {31'd0, req});
    if (req) chk({tag, ".addr"}, {18'd0, ibus_addr}, {18'd0, addr});
    chk({tag, ".push_single"}, {31'd0, push_single}, {31'd0, ps});
    chk({tag, ".push_double"}, {31'd0, push_double}, {31'd0, pd});
    chk({tag, ".clear_n"}, {31'd0, buf_clear_n}, {31'd0, cn});
  endtask

  initial begin
    rst_n        = 1'b0;
    flush        = 1'b0;
    flush_pc     = '0;
    ibus_ack     = 1'b0;
    ibus_data    = '0;
    buf_not_full = 1'b1;
    #1;
    chk_ctl("reset", 1'b0, 14'h0, 1'b0, 1'b0, 1'b0);
    chk("reset.buf_pc", {17'd0, buf_pc}, 32'h0);
    chk("reset.data", {data_hi, data_lo}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Leave reset: one clear cycle, then an idle cycle issues the first request.
    tick(); chk_ctl("clr_done", 1'b0, 14'h0, 1'b0, 1'b0, 1'b1);
    tick(); chk_ctl("issue0", 1'b1, 14'h0, 1'b0, 1'b0, 1'b1);
    ibus_ack = 1'b1; ibus_data = 32'h0013_0013;
    tick(); chk_ctl("ack0", 1'b1, 14'h1, 1'b0, 1'b1, 1'b1);
    chk("ack0.data", {data_hi, data_lo}, 32'h0013_0013);
    ibus_ack = 1'b0;
    tick(); chk_ctl("hold1", 1'b1, 14'h1, 1'b0, 1'b0, 1'b1);

    // Back-pressure at the ack: request drops, resumes after not_full returns.
    ibus_ack = 1'b1; ibus_data = 32'h1234_5678; buf_not_full = 1'b0;
    tick(); chk_ctl("bp_ack", 1'b0, 14'h0, 1'b0, 1'b1, 1'b1);
    chk("bp_ack.data", {data_hi, data_lo}, 32'h1234_5678);
    ibus_ack = 1'b0;
    tick(); chk_ctl("bp_wait0", 1'b0, 14'h0, 1'b0, 1'b0, 1'b1);
    tick(); chk_ctl("bp_wait1", 1'b0, 14'h0, 1'b0, 1'b0, 1'b1);
    buf_not_full = 1'b1;
    tick(); chk_ctl("bp_resume", 1'b1, 14'h2, 1'b0, 1'b0, 1'b1);
    ibus_ack = 1'b1; ibus_data = 32'h0; buf_not_full = 1'b0;
    tick(); chk_ctl("ack2", 1'b0, 14'h0, 1'b0, 1'b1, 1'b1);

    // Misaligned redirect to halfword 3 (byte 6).
    ibus_ack = 1'b0; flush = 1'b1; flush_pc = 15'h0003;
    tick(); chk_ctl("mis_flush", 1'b0, 14'h0, 1'b0, 1'b0, 1'b0);
    chk("mis_flush.buf_pc", {17'd0, buf_pc}, 32'h3);
    flush = 1'b0; buf_not_full = 1'b1;
    tick(); chk_ctl("mis_clr", 1'b0, 14'h0, 1'b0, 1'b0, 1'b1);
    tick(); chk_ctl("mis_issue", 1'b1, 14'h1, 1'b0, 1'b0, 1'b1);
    ibus_ack = 1'b1; ibus_data = 32'hAAAA_5555;
    tick(); chk_ctl("mis_ack", 1'b1, 14'h2, 1'b1, 1'b0, 1'b1);
    chk("mis_ack.hi", {16'd0, data_hi}, 32'hAAAA);
    ibus_data = 32'h0BAD_F00D;
    tick(); chk_ctl("mis_next", 1'b1, 14'h3, 1'b0, 1'b1, 1'b1);
    chk("mis_next.data", {data_hi, data_lo}, 32'h0BAD_F00D);

    // Flush coincident with the ack at word 3: data discarded.
    flush = 1'b1; flush_pc = 15'h0010; ibus_data = 32'hDEAD_BEEF;
    tick(); chk_ctl("coin_flush", 1'b0, 14'h0, 1'b0, 1'b0, 1'b0);
    chk("coin_flush.buf_pc", {17'd0, buf_pc}, 32'h10);
    chk("coin_flush.data_kept", {data_hi, data_lo}, 32'h0BAD_F00D);
    flush = 1'b0; ibus_ack = 1'b0;
    tick(); chk_ctl("coin_clr", 1'b0, 14'h0, 1'b0, 1'b0, 1'b1);
    tick(); chk_ctl("coin_issue", 1'b1, 14'h8, 1'b0, 1'b0, 1'b1);

    // Flush with request outstanding at word 8, retarget to word 5.
    flush = 1'b1; flush_pc = 15'h000A;
    tick(); chk_ctl("drop8_flush", 1'b1, 14'h8, 1'b0, 1'b0, 1'b0);
    flush = 1'b0;
    tick(); chk_ctl("drop8_wait", 1'b1, 14'h8, 1'b0, 1'b0, 1'b1);
    ibus_ack = 1'b1;
    tick(); chk_ctl("drop8_ack", 1'b0, 14'h0, 1'b0, 1'b0, 1'b1);
    ibus_ack = 1'b0;
    tick(); chk_ctl("issue5", 1'b1, 14'h5, 1'b0, 1'b0, 1'b1);

    // Flush with request pending at word 5, delayed ack, then word 0x20.
    flush = 1'b1; flush_pc = 15'h0040;
    tick(); chk_ctl("drop5_flush", 1'b1, 14'h5, 1'b0, 1'b0, 1'b0);
    chk("drop5_flush.buf_pc", {17'd0, buf_pc}, 32'h40);
    flush = 1'b0;
    tick(); chk_ctl("drop5_wait0", 1'b1, 14'h5, 1'b0, 1'b0, 1'b1);
    tick(); chk_ctl("drop5_wait1", 1'b1, 14'h5, 1'b0, 1'b0, 1'b1);
    ibus_ack = 1'b1; ibus_data = 32'h5A5A_A5A5;
    tick(); chk_ctl("drop5_ack", 1'b0, 14'h0, 1'b0, 1'b0, 1'b1);
    chk("drop5_ack.data_kept", {data_hi, data_lo}, 32'h0BAD_F00D);
    ibus_ack = 1'b0;
    tick(); chk_ctl("issue20", 1'b1, 14'h20, 1'b0, 1'b0, 1'b1);

    // Complete word 0x20, then redirect to the last word for the wrap run.
    ibus_ack = 1'b1; ibus_data = 32'h0; buf_not_full = 1'b0;
    tick(); chk_ctl("ack20", 1'b0, 14'h0, 1'b0, 1'b1, 1'b1);
    ibus_ack = 1'b0; flush = 1'b1; flush_pc = 15'h7FFE; buf_not_full = 1'b1;
    tick(); chk_ctl("wrap_flush", 1'b0, 14'h0, 1'b0, 1'b0, 1'b0);
    flush = 1'b0;
    tick(); chk_ctl("wrap_clr", 1'b0, 14'h0, 1'b0, 1'b0, 1'b1);
    tick(); chk_ctl("wrap_issue", 1'b1, 14'h3FFF, 1'b0, 1'b0, 1'b1);

    // Back-to-back acks: one push_double per cycle, address wraps to 0.
    ibus_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ibus_data = 32'h1000_0000 + i;
      tick();
      chk_ctl($sformatf("b2b%0d", i), 1'b1, 14'(i), 1'b0, 1'b1, 1'b1);
      chk($sformatf("b2b%0d.data", i), {data_hi, data_lo}, 32'h1000_0000 + i);
    end
    ibus_ack = 1'b0;

    // Asynchronous reset mid-request returns outputs immediately.
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk_ctl("async_rst", 1'b0, 14'h0, 1'b0, 1'b0, 1'b0);
    chk("async_rst.buf_pc", {17'd0, buf_pc}, 32'h0);
    chk("async_rst.data", {data_hi, data_lo}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
